// File: rtl/bram.sv
// bram: self-contained block-RAM exerciser.
// A start pulse fills a single-port synchronous RAM with addr+1, reads every
// word back and sums the read data into a wrapping DATA_W-bit result, then
// raises done until the next start.
module bram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              at_last;
  logic              clr;
  logic              wr_en;
  logic              rd_en;
  logic              drain;

  assign at_last = (addr == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    drain      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WRITE;
          clr        = 1'b1;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (at_last) state_next = S_READ;
      end
      S_READ: begin
        rd_en = 1'b1;
        if (at_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        drain      = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_next = S_WRITE;
          clr        = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // RAM write port; contents are deliberately not reset so the array maps to BRAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= DATA_W'(addr) + DATA_W'(1);
  end

  // Address counter, registered read, accumulator and result/done outputs.
  // DEPTH is a power of two, so addr wraps to 0 on its own at the end of each
  // WRITE and READ sweep. rd_valid is still high during DRAIN, which is where
  // the last word is folded into result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      acc      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[addr];

      if (clr) begin
        addr <= '0;
      end else if (wr_en || rd_en) begin
        addr <= addr + ADDR_W'(1);
      end

      if (clr) begin
        acc <= '0;
      end else if (rd_valid) begin
        acc <= acc + rd_data;
      end

      if (drain) result <= acc + rd_data;

      if (clr) begin
        done <= 1'b0;
      end else if (drain) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram.sv
// tb_bram: directed, table-driven bench for bram (DEPTH=16) plus a DEPTH=512
// instance for the wrap-around sum.
module tb_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;

  logic        rst_b = 1'b0;
  logic        start_b = 1'b0;
  logic        done_b;
  logic [15:0] result_b;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  bram #(.DEPTH(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .done   (done),
    .result (result)
  );

  bram #(.DEPTH(512), .ADDR_W(9), .DATA_W(16)) dut_big (
    .clk    (clk),
    .rst    (rst_b),
    .start  (start_b),
    .done   (done_b),
    .result (result_b)
  );

  typedef struct {
    string       name;
    int          extra_pulse;  // edge offset after E at which start is sampled again, 0 = none
    int          exp_lat;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one sampling edge E, then count edges until done is seen.
  task automatic run(input string name, input int extra_pulse, input int exp_lat,
                     input logic [15:0] exp_res);
    logic [15:0] res_before;
    bit          hold_ok;
    int          n;
    res_before = result;
    hold_ok    = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_drop"}, {31'd0, done}, 32'd0);
    n = 0;
    while (n < 100) begin
      start = (extra_pulse != 0) && (n + 1 == extra_pulse);
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (result !== res_before) hold_ok = 1'b0;
    end
    check({name, "_result_hold"}, {31'd0, hold_ok}, 32'd1);
    check({name, "_latency"}, n, exp_lat);
    check({name, "_result"}, {16'd0, result}, {16'd0, exp_res});
  endtask

  initial begin
    int n;
    bit idle_ok;

    vecs[0] = '{"single",       0, 33, 16'h0088};
    vecs[1] = '{"restart",      0, 33, 16'h0088};
    vecs[2] = '{"pulse_read",  20, 33, 16'h0088};
    vecs[3] = '{"pulse_drain", 33, 33, 16'h0088};

    // Reset and idle behaviour
    #20;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    rst_b = 1'b1;
    idle_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || result !== 16'h0000) idle_ok = 1'b0;
    end
    check("idle_no_activity", {31'd0, idle_ok}, 32'd1);

    // Table-driven runs
    for (int i = 0; i < 4; i++) begin
      run(vecs[i].name, vecs[i].extra_pulse, vecs[i].exp_lat, vecs[i].exp_res);
    end

    // Start held high: back-to-back runs, done high for exactly one cycle
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("b2b_first_latency", n, 32'd33);
    @(negedge clk);
    check("b2b_done_one_cycle", {31'd0, done}, 32'd0);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("b2b_period", n, 32'd34);
    check("b2b_result", {16'd0, result}, 32'h0088);
    start = 1'b0;

    // Reset mid-WRITE aborts immediately; a fresh start is needed afterwards
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) idle_ok = 1'b0;
    end
    check("midrst_no_autorun", {31'd0, idle_ok}, 32'd1);
    run("after_rst", 0, 33, 16'h0088);

    // DEPTH=512 wrap-around: sum 1..512 = 131328 -> 0x0100
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("big_latency", n, 32'd1025);
    check("big_result", {16'd0, result_b}, 32'h0100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
